// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// shift direction encoding and a helper mapping a shift mode to its direction.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  // Direction implied by a shift mode; only meaningful for MODE_SHR/MODE_SHL.
  function automatic dir_e mode_dir(input mode_e m);
    return (m == MODE_SHL) ? DIR_LEFT : DIR_RIGHT;
  endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Serial frame tracker: counts consecutive same-direction shifts, remembers
// the last shift direction and emits a one-cycle pulse when a frame of
// WIDTH same-direction shifts completes.
module shift_frame_cnt
  import shift_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  mode_e         mode,
  output logic [CW-1:0] bit_cnt,
  output logic          frame_valid
);

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  dir_e          dir_q;
  dir_e          dir_d;
  dir_e          shift_dir;
  logic [CW-1:0] cnt_d;
  logic          fv_d;

  // Next-state: a direction change restarts the frame at 1, a same-direction
  // shift on the last bit wraps and pulses, load clears, hold keeps everything.
  always_comb begin
    cnt_d     = bit_cnt;
    dir_d     = dir_q;
    fv_d      = 1'b0;
    shift_dir = mode_dir(mode);
    case (mode)
      MODE_SHR, MODE_SHL: begin
        dir_d = shift_dir;
        if (shift_dir != dir_q) begin
          cnt_d = ONE;
        end else if (bit_cnt == LAST_BIT) begin
          cnt_d = '0;
          fv_d  = 1'b1;
        end else begin
          cnt_d = bit_cnt + ONE;
        end
      end
      MODE_LOAD: cnt_d = '0;
      default: begin
      end
    endcase
  end

  // State register; reset discards any partial frame and faces right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      dir_q       <= DIR_RIGHT;
      frame_valid <= 1'b0;
    end else begin
      bit_cnt     <= cnt_d;
      dir_q       <= dir_d;
      frame_valid <= fv_d;
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right (serial in at MSB),
// shift left (serial in at LSB) and parallel load, plus serial frame tracking.
module universal_shift_reg
  import shift_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CW-1:0]    bit_cnt,
  output logic             frame_valid
);

  mode_e mode_sel;

  assign mode_sel = mode_e'(mode);

  // Data register update selected by mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (mode_sel)
        MODE_SHR:  q <= {sin, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], sin};
        MODE_LOAD: q <= pin;
        default:   q <= q;
      endcase
    end
  end

  // Bit about to leave the register on the current shift; zero otherwise.
  always_comb begin
    sout = 1'b0;
    case (mode_sel)
      MODE_SHR: sout = q[0];
      MODE_SHL: sout = q[WIDTH-1];
      default: begin
      end
    endcase
  end

  shift_frame_cnt #(
    .WIDTH(WIDTH)
  ) u_frame_cnt (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode_sel),
    .bit_cnt     (bit_cnt),
    .frame_valid (frame_valid)
  );

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset. The ports SHALL be named clk and rst.
REQ-002 Parameter: WIDTH, 4, register length in bits. Legal range is WIDTH >= 2.
REQ-003 Derived constant: CW = $clog2(WIDTH), the width of the bit counter.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 sin  input  1  serial data in.
REQ-008 pin  input  WIDTH  parallel load data.
REQ-009 q  output  WIDTH  register contents.
REQ-010 sout  output  1  bit leaving the register on the current shift: q[0] in shift right, q[WIDTH-1] in shift left, 0 otherwise. Combinational from q and mode.
REQ-011 bit_cnt  output  CW  count of consecutive same-direction shifts in the current frame.
REQ-012 frame_valid  output  1  one-cycle registered pulse marking a completed serial frame.

Function
REQ-013 Hold (00): q, bit_cnt and the direction register SHALL be unchanged. frame_valid SHALL be 0 on the next cycle.
REQ-014 Shift right (01): q SHALL become {sin, q[WIDTH-1:1]}, so the serial bit enters at the MSB (serial-in/parallel-out ordering).
REQ-015 Shift left (10): q SHALL become {q[WIDTH-2:0], sin}.
REQ-016 Parallel load (11): q SHALL become pin. bit_cnt SHALL clear to 0. frame_valid SHALL be 0 on the next cycle.
REQ-017 A 1-bit direction register SHALL record the direction of the last shift.
REQ-018 If a shift's direction differs from the direction register, bit_cnt SHALL become 1; otherwise it SHALL increment.
REQ-019 When a same-direction shift occurs with bit_cnt == WIDTH-1, bit_cnt SHALL wrap to 0 and frame_valid SHALL be 1 for exactly the following cycle.
REQ-020 For WIDTH = 2, a direction change with bit_cnt == 1 SHALL set bit_cnt to 1 with no frame_valid pulse. Wrap occurs only on same-direction shifts.
REQ-021 Back-to-back frames SHALL be supported: WIDTH further same-direction shifts SHALL produce the next pulse with no idle cycle.
REQ-022 Hold cycles inside a frame SHALL NOT break the frame; counting SHALL resume after the hold.
REQ-023 The latency from the sampling edge to the q update SHALL be one clock. frame_valid SHALL assert in the cycle after the completing edge.
REQ-024 mode and sin SHALL be sampled only at the rising clk edge. Behaviour for X on mode is unspecified.

Reset
REQ-025 On rst assertion, immediately and without a clock edge: q = 0, bit_cnt = 0, frame_valid = 0, direction register = right.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame. No frame_valid pulse SHALL follow deassertion.
REQ-027 The first clk edge after rst deassertion SHALL perform a normal operation according to mode.

Structure
REQ-028 Mode encodings SHALL live in shared package shift_pkg: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD.
REQ-029 Bit counter, direction register and frame_valid generation SHALL be one sub-module, shift_frame_cnt, parameterised by WIDTH.
REQ-030 The data vector SHALL be inferred in the top level. No per-bit flip-flop instances.

Verification (WIDTH = 4)
REQ-031 Shift right with sin = 1,0,1,1 from reset: q = 1000, 0100, 1010, 1101. bit_cnt = 1, 2, 3, 0. frame_valid = 1 for one cycle after the 4th edge.
REQ-032 Shift left with sin = 1,1,0,0 from reset: q = 0001, 0011, 0110, 1100. frame_valid pulses after the 4th edge. sout equals the prior q[3] on each shift.
REQ-033 Two right shifts, then load pin = 0110: q = 0110, bit_cnt = 0, no pulse. A pulse occurs only after 4 more shifts.
REQ-034 Three right shifts, then one left shift: bit_cnt = 1, no pulse. The pulse occurs after 3 further left shifts.
REQ-035 Five hold cycles mid-frame: q and bit_cnt unchanged, frame_valid = 0, sout = 0.
REQ-036 Load 1010, shift twice, assert rst between edges: q = 0000, bit_cnt = 0 immediately. No pulse after deassertion.
